// File: rtl/wb_stage.sv
// Write-back stage: latches the MEM->WB bus, commits to the 32x32 register file,
// serves ID's two read ports with write-through bypass, and counts retirements.

module wb_rd_port (
    input  logic [4:0]        addr,
    input  logic              wb_we,
    input  logic [4:0]        wb_waddr,
    input  logic [31:0]       wb_wdata,
    input  logic [31:0][31:0] rf,
    output logic [31:0]       data
);
    always_comb begin
        data = rf[addr];
        if (addr == 5'd0)
            data = '0;
        else if (wb_we && (wb_waddr == addr))
            data = wb_wdata;
    end
endmodule

module wb_stage #(
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    input  logic [4:0]              rs_addr,
    input  logic [4:0]              rt_addr,
    output logic [31:0]             rs_data,
    output logic [31:0]             rt_data,
    output logic [37:0]             wb_to_id,
    output logic [31:0]             debug_wb_pc,
    output logic [3:0]              debug_wb_rf_wen,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [31:0]             debug_wb_rf_wdata,
    output logic [31:0]             retired_cnt
);
    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_bus_t;

    logic [MEM_TO_WB_WD-1:0] bus_d, bus_q;
    logic                    valid_d, valid_q;
    logic [31:0][31:0]       rf_d, rf_q;
    logic [31:0]             cnt_d, cnt_q;
    wb_bus_t                 wb, in_bus;
    logic                    stop_mem, stop_wb;
    logic                    unused_stall;

    assign stop_mem     = stall[4];
    assign stop_wb      = stall[5];
    assign unused_stall = ^stall[3:0];
    assign wb           = wb_bus_t'(bus_q);
    assign in_bus       = wb_bus_t'(mem_to_wb_bus);

    // MEM stopped while WB drains: WB must see a bubble rather than a replay.
    always_comb begin
        bus_d   = bus_q;
        valid_d = valid_q;
        if (stop_mem && !stop_wb) begin
            bus_d   = '0;
            valid_d = 1'b0;
        end else if (!stop_mem) begin
            bus_d   = mem_to_wb_bus;
            valid_d = (in_bus.pc != 32'd0);
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb.we && (wb.waddr != 5'd0))
            rf_d[wb.waddr] = wb.wdata;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !stop_wb)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
            rf_q    <= '0;
            cnt_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            rf_q    <= rf_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    assign rd_addr = {rt_addr, rs_addr};

    for (genvar g = 0; g < 2; g++) begin : g_rd
        wb_rd_port u_rd (
            .addr     (rd_addr[g]),
            .wb_we    (wb.we),
            .wb_waddr (wb.waddr),
            .wb_wdata (wb.wdata),
            .rf       (rf_q),
            .data     (rd_data[g])
        );
    end

    assign rs_data           = rd_data[0];
    assign rt_data           = rd_data[1];
    assign wb_to_id          = {wb.we, wb.waddr, wb.wdata};
    assign debug_wb_pc       = wb.pc;
    assign debug_wb_rf_wen   = {4{wb.we}};
    assign debug_wb_rf_wnum  = wb.waddr;
    assign debug_wb_rf_wdata = wb.wdata;
    assign retired_cnt       = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic against a
// behavioural model of the WB stage (fields, register array, retire count).

module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [69:0] mem_to_wb_bus;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [37:0] wb_to_id;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_rf [32];
    logic [31:0] m_pc, m_wdata, m_cnt;
    logic        m_we, m_valid;
    logic [4:0]  m_waddr;

    wb_stage #(.MEM_TO_WB_WD(70), .STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall), .mem_to_wb_bus(mem_to_wb_bus),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_to_id(wb_to_id), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] mk(input logic [31:0] pc, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
        return {pc, we, wa, wd};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_we && m_waddr == a) return m_wdata;
        return m_rf[a];
    endfunction

    // One clock edge: drive inputs, then advance the model by the stage's rules.
    task automatic cyc(input logic [5:0] st, input logic [69:0] b, input logic r);
        stall = st; mem_to_wb_bus = b; rst = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            {m_pc, m_we, m_waddr, m_wdata} = '0;
            m_valid = 1'b0; m_cnt = 32'd0;
        end else begin
            if (m_we && m_waddr != 5'd0) m_rf[m_waddr] = m_wdata;
            if (m_valid && !st[5]) m_cnt = m_cnt + 32'd1;
            if (st[4] && !st[5]) begin
                {m_pc, m_we, m_waddr, m_wdata} = '0;
                m_valid = 1'b0;
            end else if (!st[4]) begin
                {m_pc, m_we, m_waddr, m_wdata} = b;
                m_valid = (b[69:38] != 32'd0);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(6'd0, '0, 1'b1);
        cyc(6'd0, '0, 1'b0);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(31 - a); #1;
            checks++;
            if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_read a=%0d: rs=%h rt=%h exp 0", a, rs_data, rt_data);
            end
        end
        checks++;
        if (retired_cnt !== 32'd0 || debug_wb_rf_wen !== 4'd0 || wb_to_id !== 38'd0 ||
            debug_wb_pc !== 32'd0 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: cnt=%h wen=%h id=%h pc=%h exp all 0",
                     retired_cnt, debug_wb_rf_wen, wb_to_id, debug_wb_pc);
        end
    endtask

    task automatic test_write_bypass();
        cyc(6'd0, mk(32'hBFC00000, 1'b1, 5'd5, 32'h12345678), 1'b0);
        rs_addr = 5'd5; #1;
        checks++;
        if (rs_data !== 32'h12345678) begin
            errors++; $display("FAIL bypass_rs: got %h exp %h", rs_data, 32'h12345678);
        end
        checks++;
        if (debug_wb_pc !== 32'hBFC00000) begin
            errors++; $display("FAIL bypass_pc: got %h exp %h", debug_wb_pc, 32'hBFC00000);
        end
        cyc(6'd0, '0, 1'b0);
        rs_addr = 5'd5; #1;
        checks++;
        if (rs_data !== 32'h12345678) begin
            errors++; $display("FAIL file_rs: got %h exp %h", rs_data, 32'h12345678);
        end
        checks++;
        if (retired_cnt !== 32'd1) begin
            errors++; $display("FAIL retire_one: got %0d exp 1", retired_cnt);
        end
    endtask

    task automatic test_r0();
        cyc(6'd0, mk(32'hBFC00004, 1'b1, 5'd0, 32'hFFFFFFFF), 1'b0);
        rs_addr = 5'd0; #1;
        checks++;
        if (rs_data !== 32'd0 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wen !== 4'hF) begin
            errors++;
            $display("FAIL r0_bypass: rs=%h wnum=%0d wen=%h exp 0/0/f", rs_data, debug_wb_rf_wnum, debug_wb_rf_wen);
        end
        cyc(6'd0, '0, 1'b0);
        rs_addr = 5'd0; #1;
        checks++;
        if (rs_data !== 32'd0) begin
            errors++; $display("FAIL r0_file: got %h exp 0", rs_data);
        end
    endtask

    task automatic test_stall_bubble();
        logic [31:0] c;
        cyc(6'd0, mk(32'hBFC00010, 1'b1, 5'd7, 32'h0000_7777), 1'b0);
        cyc(6'b010000, mk(32'hBFC00014, 1'b1, 5'd8, 32'h0000_8888), 1'b0);
        checks++;
        if (wb_to_id !== 38'd0 || debug_wb_pc !== 32'd0) begin
            errors++; $display("FAIL bubble_id: id=%h pc=%h exp 0", wb_to_id, debug_wb_pc);
        end
        checks++;
        if (retired_cnt !== m_cnt) begin
            errors++; $display("FAIL bubble_cnt_drain: got %0d exp %0d", retired_cnt, m_cnt);
        end
        c = retired_cnt;
        cyc(6'b010000, mk(32'hBFC00014, 1'b1, 5'd8, 32'h0000_8888), 1'b0);
        checks++;
        if (retired_cnt !== c) begin
            errors++; $display("FAIL bubble_cnt_hold: got %0d exp %0d", retired_cnt, c);
        end
        rt_addr = 5'd8; #1;
        checks++;
        if (rt_data !== 32'd0) begin
            errors++; $display("FAIL bubble_nowrite: got %h exp 0", rt_data);
        end
    endtask

    task automatic test_hold();
        logic [31:0] c;
        cyc(6'd0, mk(32'hBFC00020, 1'b1, 5'd9, 32'hCAFE_0009), 1'b0);
        c = retired_cnt;
        for (int i = 0; i < 3; i++) begin
            cyc(6'b110000, mk(32'hDEAD0000, 1'b1, 5'd10, 32'h1111_1111), 1'b0);
            checks++;
            if (wb_to_id !== {1'b1, 5'd9, 32'hCAFE_0009} || debug_wb_pc !== 32'hBFC00020 ||
                retired_cnt !== c) begin
                errors++;
                $display("FAIL hold_%0d: id=%h pc=%h cnt=%0d exp %h %h %0d", i, wb_to_id,
                         debug_wb_pc, retired_cnt, {1'b1, 5'd9, 32'hCAFE_0009}, 32'hBFC00020, c);
            end
        end
        cyc(6'd0, '0, 1'b0);
        checks++;
        if (retired_cnt !== c + 32'd1) begin
            errors++; $display("FAIL hold_release_cnt: got %0d exp %0d", retired_cnt, c + 32'd1);
        end
    endtask

    task automatic test_back_to_back();
        cyc(6'd0, mk(32'hBFC00030, 1'b1, 5'd3, 32'hA), 1'b0);
        rt_addr = 5'd3; rs_addr = 5'd3; #1;
        checks++;
        if (rt_data !== 32'hA || rs_data !== rt_data) begin
            errors++; $display("FAIL b2b_first: rt=%h rs=%h exp a", rt_data, rs_data);
        end
        cyc(6'd0, mk(32'hBFC00034, 1'b1, 5'd3, 32'hB), 1'b0);
        rt_addr = 5'd3; #1;
        checks++;
        if (rt_data !== 32'hB) begin
            errors++; $display("FAIL b2b_second: got %h exp b", rt_data);
        end
        cyc(6'd0, '0, 1'b0);
        rt_addr = 5'd3; #1;
        checks++;
        if (rt_data !== 32'hB) begin
            errors++; $display("FAIL b2b_file: got %h exp b", rt_data);
        end
        cyc(6'b110000, '0, 1'b1);
        cyc(6'd0, '0, 1'b0);
        rt_addr = 5'd3; #1;
        checks++;
        if (rt_data !== 32'd0 || retired_cnt !== 32'd0) begin
            errors++; $display("FAIL b2b_reset: rt=%h cnt=%0d exp 0/0", rt_data, retired_cnt);
        end
    endtask

    task automatic test_random();
        logic [5:0]  st;
        logic [69:0] b;
        logic [4:0]  a0, a1;
        for (int n = 0; n < 400; n++) begin
            st = {2'($urandom_range(0, 3)), 4'($urandom)};
            if ($urandom_range(0, 1) == 0) st[5:4] = 2'b00;
            if ($urandom_range(0, 3) == 0) b = '0;
            else b = mk(($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, 1'($urandom),
                        5'($urandom_range(0, 7)), $urandom);
            cyc(st, b, ($urandom_range(0, 99) == 0));
            a0 = 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 7));
            rs_addr = a0; rt_addr = a1; #1;
            checks++;
            if (rs_data !== exp_rd(a0) || rt_data !== exp_rd(a1)) begin
                errors++;
                $display("FAIL rand_read n=%0d rs[%0d]=%h rt[%0d]=%h exp %h %h", n, a0, rs_data,
                         a1, rt_data, exp_rd(a0), exp_rd(a1));
            end
            checks++;
            if (wb_to_id !== {m_we, m_waddr, m_wdata} || debug_wb_pc !== m_pc ||
                debug_wb_rf_wen !== {4{m_we}} || debug_wb_rf_wnum !== m_waddr ||
                debug_wb_rf_wdata !== m_wdata || retired_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_outs n=%0d id=%h pc=%h cnt=%0d exp id=%h pc=%h cnt=%0d", n,
                         wb_to_id, debug_wb_pc, retired_cnt, {m_we, m_waddr, m_wdata}, m_pc, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = '0; mem_to_wb_bus = '0; rs_addr = '0; rt_addr = '0;
        test_reset();
        test_write_bypass();
        test_r0();
        test_stall_bubble();
        test_hold();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
